// File: rtl/dm_bytelane_if.sv
// Load/store bus between the MEM stage and the byte-lane data memory.
interface dm_bytelane_if;
   logic [31:0] addr;
   logic [31:0] Data_In;
   logic        Write_en;
   logic        Read_en;
   logic [1:0]  size;
   logic        unsigned_ld;
   logic [31:0] Data_Out;
   logic        misaligned;
   logic        busy;

   modport master (
      output addr, Data_In, Write_en, Read_en, size, unsigned_ld,
      input  Data_Out, misaligned, busy
   );

   modport slave (
      input  addr, Data_In, Write_en, Read_en, size, unsigned_ld,
      output Data_Out, misaligned, busy
   );
endinterface

// File: rtl/dm_bytelane.sv
// Byte-addressed data memory with byte/half/word lane stores, sign/zero
// extended sub-word loads, 1-cycle read latency, misalignment detection and
// an optional post-reset clear sweep.
module dm_bytelane #(
   parameter int ADDR_WIDTH     = 10,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input logic          clk,
   input logic          rst_n,
   dm_bytelane_if.slave bus
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {
      CLEAR,
      READY
   } state_t;

   localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : READY;

   // ---------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------
   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] ofs);
      case (sz)
         2'b00:   is_misaligned = 1'b0;
         2'b01:   is_misaligned = ofs[0];
         2'b10:   is_misaligned = |ofs;
         default: is_misaligned = 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] ofs);
      case (sz)
         2'b00:   lane_mask = 4'b0001 << ofs;
         2'b01:   lane_mask = ofs[1] ? 4'b1100 : 4'b0011;
         2'b10:   lane_mask = 4'b1111;
         default: lane_mask = 4'b0000;
      endcase
   endfunction

   // Replicate right-aligned store data onto every lane it could land on.
   function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
      case (sz)
         2'b00:   lane_data = {4{d[7:0]}};
         2'b01:   lane_data = {2{d[15:0]}};
         default: lane_data = d;
      endcase
   endfunction

   // Pick the addressed lane(s) out of a word and extend to 32 bits.
   function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] ofs, input logic uns);
      logic [31:0]        shifted;
      logic signed [7:0]  b;
      logic signed [15:0] h;
      shifted = word >> {ofs, 3'b000};
      b       = shifted[7:0];
      h       = shifted[15:0];
      case (sz)
         2'b00:   extend_load = uns ? {24'd0, b} : 32'(b);
         2'b01:   extend_load = uns ? {16'd0, h} : 32'(h);
         default: extend_load = word;
      endcase
   endfunction

   // ---------------------------------------------------------------------
   // Request decode (p0)
   // ---------------------------------------------------------------------
   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic [3:0][7:0]       mem [DEPTH];

   logic [ADDR_WIDTH-1:0] idx_p0;
   logic [1:0]            ofs_p0;
   logic                  mis_p0;
   logic                  active_p0;
   logic                  rd_fire_p0;
   logic                  unused_addr_hi;

   assign idx_p0         = bus.addr[ADDR_WIDTH+1:2];
   assign ofs_p0         = bus.addr[1:0];
   assign mis_p0         = is_misaligned(bus.size, ofs_p0);
   assign active_p0      = (state == READY);
   assign rd_fire_p0     = active_p0 && bus.Read_en && !mis_p0;
   assign unused_addr_hi = ^bus.addr[31:ADDR_WIDTH+2];

   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_idx;
   logic [3:0]            wr_mask;
   logic [31:0]           wr_data;

   // Next-state and write-port steering: clear sweep owns the port while busy.
   always_comb begin
      state_next = state;
      wr_en      = 1'b0;
      wr_idx     = idx_p0;
      wr_mask    = 4'b0000;
      wr_data    = lane_data(bus.size, bus.Data_In);
      case (state)
         CLEAR: begin
            wr_en   = 1'b1;
            wr_idx  = clr_cnt;
            wr_mask = 4'b1111;
            wr_data = 32'd0;
            if (clr_cnt == {ADDR_WIDTH{1'b1}}) state_next = READY;
         end
         READY: begin
            if (bus.Write_en && !mis_p0) begin
               wr_en   = 1'b1;
               wr_mask = lane_mask(bus.size, ofs_p0);
            end
         end
         default: state_next = RESET_STATE;
      endcase
   end

   // FSM state register and clear counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RESET_STATE;
         clr_cnt <= '0;
      end else begin
         state <= state_next;
         if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Array access / load capture (p1)
   // ---------------------------------------------------------------------
   logic [31:0] rd_word_p1;
   logic [1:0]  rd_size_p1;
   logic [1:0]  rd_ofs_p1;
   logic        rd_uns_p1;
   logic        vld_p1;
   logic        mis_p1;

   // Array write with byte enables; the read below samples pre-write contents.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_en && wr_mask[i]) mem[wr_idx][i] <= wr_data[i*8 +: 8];
      end
      if (rd_fire_p0) begin
         rd_word_p1 <= mem[idx_p0];
         rd_size_p1 <= bus.size;
         rd_ofs_p1  <= ofs_p0;
         rd_uns_p1  <= bus.unsigned_ld;
      end
   end

   // Load-valid and misalignment flags; a rejected load forces the output to 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         mis_p1 <= 1'b0;
      end else begin
         if (active_p0 && bus.Read_en) vld_p1 <= !mis_p0;
         mis_p1 <= active_p0 && (bus.Write_en || bus.Read_en) && mis_p0;
      end
   end

   assign bus.Data_Out   = vld_p1 ? extend_load(rd_word_p1, rd_size_p1, rd_ofs_p1, rd_uns_p1)
                                  : 32'd0;
   assign bus.misaligned = mis_p1;
   assign bus.busy       = (state == CLEAR);

endmodule

// File: tb/tb_dm_bytelane.sv
// Directed bench for dm_bytelane: clear sweep, lane stores, extended loads,
// misalignment, read-first collisions, address wrap and mid-clear reset.
module tb_dm_bytelane;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   n;

   dm_bytelane_if bus1 ();
   dm_bytelane_if bus0 ();

   dm_bytelane #(.ADDR_WIDTH(4), .CLEAR_ON_RESET(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   dm_bytelane #(.ADDR_WIDTH(4), .CLEAR_ON_RESET(1'b0)) dut_noclr (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   assign bus0.addr        = bus1.addr;
   assign bus0.Data_In     = bus1.Data_In;
   assign bus0.Write_en    = bus1.Write_en;
   assign bus0.Read_en     = bus1.Read_en;
   assign bus0.size        = bus1.size;
   assign bus0.unsigned_ld = bus1.unsigned_ld;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic we, input logic re, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] sz, input logic uns);
      bus1.Write_en    = we;
      bus1.Read_en     = re;
      bus1.addr        = a;
      bus1.Data_In     = d;
      bus1.size        = sz;
      bus1.unsigned_ld = uns;
   endtask

   task automatic drive(input logic we, input logic re, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz, input logic uns);
      set_req(we, re, a, d, sz, uns);
      @(posedge clk);
      #1;
      set_req(1'b0, 1'b0, 32'd0, 32'd0, 2'b10, 1'b0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      set_req(1'b0, 1'b0, 32'd0, 32'd0, 2'b10, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(bus1.busy), 32'd1);
      chk("rst_dout", bus1.Data_Out, 32'd0);
      chk("rst_mis", 32'(bus1.misaligned), 32'd0);
      chk("rst_busy_noclr", 32'(bus0.busy), 32'd0);

      // Clear sweep; the no-clear instance serves a store+load meanwhile.
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (bus1.busy && n < 100) begin
         if (n == 0)      set_req(1'b1, 1'b0, 32'h0, 32'hCAFEF00D, 2'b10, 1'b0);
         else if (n == 1) set_req(1'b0, 1'b1, 32'h0, 32'd0, 2'b10, 1'b0);
         else             set_req(1'b0, 1'b0, 32'h0, 32'd0, 2'b10, 1'b0);
         @(posedge clk);
         #1;
         n++;
         if (n == 2) begin
            chk("noclr_rd", bus0.Data_Out, 32'hCAFEF00D);
            chk("busy_ld_dout", bus1.Data_Out, 32'd0);
         end
      end
      set_req(1'b0, 1'b0, 32'd0, 32'd0, 2'b10, 1'b0);
      chk("clear_len", 32'(n), 32'd16);

      for (int w = 0; w < 16; w++) begin
         drive(1'b0, 1'b1, 32'(w * 4), 32'd0, 2'b10, 1'b0);
         chk($sformatf("clr_rd%0d", w), bus1.Data_Out, 32'd0);
      end

      // Byte loads from a word store.
      drive(1'b1, 1'b0, 32'h8, 32'h80FF7F01, 2'b10, 1'b0);
      drive(1'b0, 1'b1, 32'h8, 32'd0, 2'b00, 1'b0);
      chk("lb_8", bus1.Data_Out, 32'h00000001);
      drive(1'b0, 1'b1, 32'h9, 32'd0, 2'b00, 1'b0);
      chk("lb_9", bus1.Data_Out, 32'h0000007F);
      drive(1'b0, 1'b1, 32'hA, 32'd0, 2'b00, 1'b0);
      chk("lb_a", bus1.Data_Out, 32'hFFFFFFFF);
      drive(1'b0, 1'b1, 32'hB, 32'd0, 2'b00, 1'b0);
      chk("lb_b", bus1.Data_Out, 32'hFFFFFF80);
      drive(1'b0, 1'b1, 32'hB, 32'd0, 2'b00, 1'b1);
      chk("lbu_b", bus1.Data_Out, 32'h00000080);

      // Half store over a word.
      drive(1'b1, 1'b0, 32'h4, 32'h11223344, 2'b10, 1'b0);
      drive(1'b1, 1'b0, 32'h6, 32'h0000BEEF, 2'b01, 1'b0);
      drive(1'b0, 1'b1, 32'h4, 32'd0, 2'b10, 1'b0);
      chk("sh_word", bus1.Data_Out, 32'hBEEF3344);
      drive(1'b0, 1'b1, 32'h6, 32'd0, 2'b01, 1'b0);
      chk("lh_6", bus1.Data_Out, 32'hFFFFBEEF);
      drive(1'b0, 1'b1, 32'h4, 32'd0, 2'b01, 1'b1);
      chk("lhu_4", bus1.Data_Out, 32'h00003344);

      // Misaligned accesses.
      drive(1'b1, 1'b0, 32'h2, 32'hDEADBEEF, 2'b10, 1'b0);
      chk("mis_st", 32'(bus1.misaligned), 32'd1);
      drive(1'b0, 1'b0, 32'h2, 32'd0, 2'b10, 1'b0);
      chk("mis_pulse", 32'(bus1.misaligned), 32'd0);
      chk("idle_hold", bus1.Data_Out, 32'h00003344);
      drive(1'b0, 1'b1, 32'h3, 32'd0, 2'b01, 1'b0);
      chk("mis_ld", 32'(bus1.misaligned), 32'd1);
      chk("mis_ld_dout", bus1.Data_Out, 32'd0);
      drive(1'b0, 1'b1, 32'h0, 32'd0, 2'b10, 1'b0);
      chk("mis_st_nowr", bus1.Data_Out, 32'd0);
      chk("aligned_mis", 32'(bus1.misaligned), 32'd0);
      drive(1'b0, 1'b1, 32'h0, 32'd0, 2'b11, 1'b0);
      chk("mis_rsvd", 32'(bus1.misaligned), 32'd1);

      // Read-first on a same-cycle write/read collision.
      drive(1'b1, 1'b0, 32'h10, 32'h12345678, 2'b10, 1'b0);
      drive(1'b1, 1'b1, 32'h10, 32'hA5A5A5A5, 2'b10, 1'b0);
      chk("rw_old", bus1.Data_Out, 32'h12345678);
      drive(1'b0, 1'b1, 32'h10, 32'd0, 2'b10, 1'b0);
      chk("rw_new", bus1.Data_Out, 32'hA5A5A5A5);

      // Address wrap above the word-index bits.
      drive(1'b1, 1'b0, 32'h40, 32'h0BADC0DE, 2'b10, 1'b0);
      drive(1'b0, 1'b1, 32'h0, 32'd0, 2'b10, 1'b0);
      chk("wrap", bus1.Data_Out, 32'h0BADC0DE);

      // Reset, then reset again in the middle of the clear sweep.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst2_dout", bus1.Data_Out, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (7) @(posedge clk);
      #1;
      chk("mid_busy", 32'(bus1.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("pulse_busy", 32'(bus1.busy), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (bus1.busy && n < 100) begin
         if (n == 0) set_req(1'b0, 1'b1, 32'h40, 32'd0, 2'b10, 1'b0);
         else        set_req(1'b0, 1'b0, 32'h0, 32'd0, 2'b10, 1'b0);
         @(posedge clk);
         #1;
         n++;
         if (n == 1) begin
            chk("busy_ld2_dout", bus1.Data_Out, 32'd0);
            chk("busy_ld2_mis", 32'(bus1.misaligned), 32'd0);
         end
      end
      set_req(1'b0, 1'b0, 32'd0, 32'd0, 2'b10, 1'b0);
      chk("restart_len", 32'(n), 32'd16);
      drive(1'b0, 1'b1, 32'h10, 32'd0, 2'b10, 1'b0);
      chk("recleared", bus1.Data_Out, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dm_bytelane.md
Name: dm_bytelane

Overview:
- Parametrised data memory for the pipelined core and successor to the word-only data memory.
- Byte-addressed with byte/half/word stores through byte-lane enables and sign- or zero-extended sub-word loads.
- Synchronous 1-cycle read latency; misaligned-access detection; optional hardware clear sequence after reset.
- Sits in the MEM stage; the pipeline must stall while busy=1.

Parameters:
- ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH 32-bit words.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset release; 0 = contents untouched and ready immediately.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- addr  input  32  byte address; word index = addr[ADDR_WIDTH+1:2], upper bits ignored (wrap).
- Data_In  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- Write_en  input  1  store request.
- Read_en  input  1  load request.
- size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as misaligned).
- unsigned_ld  input  1  1 = zero-extend sub-word load; 0 = sign-extend.
- Data_Out  output  32  registered, extended load result.
- misaligned  output  1  registered 1-cycle pulse flagging a rejected access.
- busy  output  1  high during the clear sequence.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Data_Out=0, misaligned=0.
  - busy=1 if CLEAR_ON_RESET, else 0.
  - Clear counter=0; FSM to CLEAR (or READY if CLEAR_ON_RESET=0).
  - Memory array is not reset.
- FSM CLEAR:
  - Each cycle writes 0 to word[counter], then counter+1.
  - Last write at counter = 2**ADDR_WIDTH-1; next state READY, busy=0 from the following cycle.
  - Clear takes exactly 2**ADDR_WIDTH cycles after the first edge with rst_n=1.
  - Write_en/Read_en ignored: no store, Data_Out holds, misaligned stays 0.
  - rst_n assertion mid-clear restarts the clear at word 0.
- FSM READY: serves accesses; remains in READY until reset.
- Alignment:
  - Access is misaligned if size=01 and addr[0]=1, if size=10 and addr[1:0]!=0, or if size=11.
  - Misaligned store: memory unchanged.
  - Misaligned load: Data_Out <= 0.
  - misaligned=1 on the next cycle if Write_en or Read_en was high; otherwise 0.
- Stores (little-endian lanes):
  - Byte: lane addr[1:0] <= Data_In[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} <= Data_In[15:0].
  - Word: all lanes <= Data_In.
  - Other lanes preserved.
- Loads:
  - Data_Out is valid on the edge after the request (latency 1).
  - Selected lane(s) are extended per size and unsigned_ld.
  - size, unsigned_ld and addr[1:0] are registered alongside the read.
  - When Read_en=0, Data_Out holds its previous value.
- Simultaneous Write_en and Read_en at the same word: read-first; Data_Out returns pre-write contents, and the new data is visible on the next read.
- Address wrap: addresses differing only above bit ADDR_WIDTH+1 alias the same word.
- No combinational path from inputs to outputs.

Test Plan:
- Reset release with CLEAR_ON_RESET=1, ADDR_WIDTH=4 -> busy=1 for exactly 16 cycles; afterwards a word read of every address returns 0.
- Word store 0x80FF7F01 at addr 0x8, then byte loads at 0x8..0xB signed -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; unsigned at 0xB -> 0x00000080.
- Half store 0xBEEF at addr 0x6 over word 0x11223344 at 0x4 -> word read returns 0xBEEF3344; signed half load at 0x6 -> 0xFFFFBEEF.
- Word store at addr 0x2 and half load at addr 0x3 -> misaligned=1 one cycle later; memory unchanged; Data_Out=0.
- Same-cycle word write 0xA5A5A5A5 and read at addr 0x10 holding 0x12345678 -> Data_Out=0x12345678; next read -> 0xA5A5A5A5.
- rst_n pulsed low at clear cycle 7 -> busy stays 1 for a full 2**ADDR_WIDTH cycles after release; load issued while busy=1 leaves Data_Out=0. With ADDR_WIDTH=4, store at addr 0x40 -> visible when reading addr 0x0 (wrap).
